// File: rtl/sensor_scanner.sv
// Polls NUM_SENSORS sensors over a shared req/ack bus, range-checks and times out each reading,
// and publishes a coherent snapshot once per sweep.
module sensor_scanner #(
  parameter int unsigned NUM_SENSORS = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SCAN_PERIOD = 1000,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned MAX_VALID   = 120
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  output logic                          sensor_req_o,
  output logic [NUM_SENSORS-1:0]        sensor_sel_o,
  input  logic                          sensor_ack_i,
  input  logic [DATA_W-1:0]             sensor_data_i,
  output logic [NUM_SENSORS*DATA_W-1:0] sensors_data_o,
  output logic [NUM_SENSORS-1:0]        sensors_en_o,
  output logic                          frame_valid_o,
  output logic                          busy_o
);

  localparam int unsigned IdxW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned PerW = $clog2(SCAN_PERIOD + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SENSORS - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [PerW-1:0] PerLast = PerW'(SCAN_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAcq,
    StNext,
    StCommit
  } state_e;

  state_e                              state_q, state_d;
  logic [IdxW-1:0]                     idx_q, idx_d;
  logic [TmoW-1:0]                     tmo_q, tmo_d;
  logic [PerW-1:0]                     period_q, period_d;
  logic [NUM_SENSORS-1:0][DATA_W-1:0]  shadow_data_q, shadow_data_d;
  logic [NUM_SENSORS-1:0]              shadow_en_q, shadow_en_d;
  logic [NUM_SENSORS*DATA_W-1:0]       snap_data_q, snap_data_d;
  logic [NUM_SENSORS-1:0]              snap_en_q, snap_en_d;
  logic                                frame_valid_q, frame_valid_d;
  logic                                reading_ok;

  assign reading_ok = (32'(sensor_data_i) <= MAX_VALID);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    period_d      = '0;  // only IDLE counts; leaving IDLE clears it
    shadow_data_d = shadow_data_q;
    shadow_en_d   = shadow_en_q;
    snap_data_d   = snap_data_q;
    snap_en_d     = snap_en_q;
    frame_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (period_q == PerLast) begin
          idx_d   = '0;
          state_d = StAcq;
        end else begin
          period_d = period_q + 1'b1;
        end
      end

      StAcq: begin
        // An ack in the final timeout cycle still delivers its reading.
        if (sensor_ack_i) begin
          shadow_data_d[idx_q] = reading_ok ? sensor_data_i : '0;
          shadow_en_d[idx_q]   = reading_ok;
          state_d              = StNext;
        end else if (tmo_q == TmoLast) begin
          shadow_data_d[idx_q] = '0;
          shadow_en_d[idx_q]   = 1'b0;
          state_d              = StNext;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StNext: begin
        tmo_d = '0;
        if (idx_q == LastIdx) begin
          state_d = StCommit;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StAcq;
        end
      end

      StCommit: begin
        snap_data_d   = shadow_data_q;
        snap_en_d     = shadow_en_q;
        frame_valid_d = 1'b1;
        state_d       = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      tmo_q         <= '0;
      period_q      <= '0;
      shadow_data_q <= '0;
      shadow_en_q   <= '0;
      snap_data_q   <= '0;
      snap_en_q     <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      period_q      <= period_d;
      shadow_data_q <= shadow_data_d;
      shadow_en_q   <= shadow_en_d;
      snap_data_q   <= snap_data_d;
      snap_en_q     <= snap_en_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign sensor_req_o   = (state_q == StAcq);
  assign sensor_sel_o   = sensor_req_o ? (NUM_SENSORS'(1) << idx_q) : '0;
  assign busy_o         = (state_q != StIdle);
  assign sensors_data_o = snap_data_q;
  assign sensors_en_o   = snap_en_q;
  assign frame_valid_o  = frame_valid_q;

endmodule

// File: tb/tb_sensor_scanner.sv
// Randomised bench for sensor_scanner: a behavioural sensor model answers each poll and a
// per-sweep reference computes the expected snapshot, req durations and frame latency.
module tb_sensor_scanner;

  localparam int unsigned NS = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned SP = 10;
  localparam int unsigned TO = 16;
  localparam int unsigned MV = 120;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               sensor_req_o;
  logic [NS-1:0]      sensor_sel_o;
  logic               sensor_ack_i;
  logic [DW-1:0]      sensor_data_i;
  logic [NS*DW-1:0]   sensors_data_o;
  logic [NS-1:0]      sensors_en_o;
  logic               frame_valid_o;
  logic               busy_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Per-sweep sensor behaviour: ack on req cycle dly[i] (0-based), never if dly[i] >= TO.
  int unsigned      dly [NS];
  int unsigned      val [NS];
  logic [NS*DW-1:0] exp_data = '0;
  logic [NS-1:0]    exp_en   = '0;

  sensor_scanner #(
    .NUM_SENSORS (NS),
    .DATA_W      (DW),
    .SCAN_PERIOD (SP),
    .TIMEOUT     (TO),
    .MAX_VALID   (MV)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .sensor_req_o   (sensor_req_o),
    .sensor_sel_o   (sensor_sel_o),
    .sensor_ack_i   (sensor_ack_i),
    .sensor_data_i  (sensor_data_i),
    .sensors_data_o (sensors_data_o),
    .sensors_en_o   (sensors_en_o),
    .frame_valid_o  (frame_valid_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Random ack/data outside ACQ must be ignored by the DUT.
  task automatic drive_noise();
    sensor_ack_i  = 1'($urandom);
    sensor_data_i = DW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {sensor_req_o, sensor_sel_o, sensors_data_o, sensors_en_o, frame_valid_o,
                    busy_o}, '0);
  endtask

  task automatic set_sweep(input int unsigned max_dly, input bit wild);
    for (int i = 0; i < NS; i++) begin
      dly[i] = $urandom_range(max_dly, 0);
      if (wild) val[i] = ($urandom_range(1, 0) == 1) ? $urandom_range(130, 110)
                                                     : $urandom_range(255, 0);
      else      val[i] = $urandom_range(MV, 0);
    end
  endtask

  // Caller sits on the negedge of reset release or of the frame pulse.
  task automatic wait_sweep_start(output bit ok);
    int n = 0;
    while (n < SP + 20) begin
      @(negedge clk_i);
      n++;
      if (sensor_req_o) break;
      check_val("idle_fv_busy", {frame_valid_o, busy_o}, 2'b00);
      drive_noise();
    end
    check_val("idle_len", n, SP);
    ok = sensor_req_o;
  endtask

  task automatic do_abort();
    #2;
    rst_n_i = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_data = '0;
    exp_en   = '0;
    repeat (3) begin
      @(negedge clk_i);
      drive_noise();
      check_all_zero("rst_hold");
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    drive_noise();
  endtask

  // abort_at < NS resets the DUT on that sensor's first req cycle.
  task automatic run_sweep(input int unsigned abort_at);
    bit               ok;
    int unsigned      cyc;
    int unsigned      hi;
    int unsigned      lat;
    logic [NS*DW-1:0] nd;
    logic [NS-1:0]    ne;

    nd  = '0;
    ne  = '0;
    lat = 1;
    for (int i = 0; i < NS; i++) begin
      if (dly[i] < TO && val[i] <= MV) begin
        nd[i*DW +: DW] = DW'(val[i]);
        ne[i]          = 1'b1;
      end
      lat += ((dly[i] < TO) ? dly[i] + 1 : TO) + 1;
    end

    wait_sweep_start(ok);
    if (!ok) return;
    cyc = 0;

    for (int i = 0; i < NS; i++) begin
      hi = 0;
      while (sensor_req_o && hi < TO + 4) begin
        check_val("sel", sensor_sel_o, NS'(1) << i);
        check_val("hold", {sensors_en_o, sensors_data_o, frame_valid_o, busy_o},
                  {exp_en, exp_data, 1'b0, 1'b1});
        if (i == int'(abort_at)) begin
          do_abort();
          return;
        end
        if (hi == dly[i]) begin
          sensor_ack_i  = 1'b1;
          sensor_data_i = DW'(val[i]);
        end else begin
          sensor_ack_i  = 1'b0;
          sensor_data_i = DW'($urandom);
        end
        hi++;
        @(negedge clk_i);
        cyc++;
      end
      check_val("req_len", hi, (dly[i] < TO) ? dly[i] + 1 : TO);
      check_val("next", {sensor_req_o, sensor_sel_o, busy_o}, {1'b0, NS'(0), 1'b1});
      drive_noise();
      @(negedge clk_i);
      cyc++;
      if (i < NS - 1) check_val("gap_one", sensor_req_o, 1'b1);
    end

    check_val("commit", {sensor_req_o, busy_o, frame_valid_o, sensors_data_o},
              {1'b0, 1'b1, 1'b0, exp_data});
    drive_noise();
    @(negedge clk_i);
    cyc++;
    check_val("pulse", {frame_valid_o, busy_o}, 2'b10);
    check_val("snap_data", sensors_data_o, nd);
    check_val("snap_en", sensors_en_o, ne);
    check_val("latency", cyc, lat);
    exp_data = nd;
    exp_en   = ne;
    drive_noise();
  endtask

  initial begin
    rst_n_i       = 1'b0;
    sensor_ack_i  = 1'b0;
    sensor_data_i = '0;
    #1;
    check_all_zero("reset");
    repeat (3) begin
      @(negedge clk_i);
      drive_noise();
    end
    check_all_zero("reset_clk");
    rst_n_i = 1'b1;

    // All sensors ack at once with 20..24.
    for (int i = 0; i < NS; i++) begin
      dly[i] = 0;
      val[i] = 20 + i;
    end
    run_sweep(NS);
    check_val("s1_data", sensors_data_o, 40'h1817161514);
    check_val("s1_en", sensors_en_o, 5'b11111);

    // Sensor 2 dead.
    set_sweep(3, 1'b0);
    dly[2] = 99;
    run_sweep(NS);
    check_val("s2_en", sensors_en_o, 5'b11011);
    check_val("s2_byte2", sensors_data_o[2*DW +: DW], 8'h00);

    // Out-of-range reading on sensor 4, boundary value on sensor 0.
    set_sweep(0, 1'b0);
    val[4] = 200;
    val[0] = MV;
    run_sweep(NS);
    check_val("s3_en", sensors_en_o, 5'b01111);
    check_val("s3_byte0", sensors_data_o[DW-1:0], 8'd120);
    check_val("s3_byte4", sensors_data_o[4*DW +: DW], 8'h00);

    // Sensor 1 acks in its last allowed cycle.
    set_sweep(4, 1'b0);
    dly[1] = TO - 1;
    run_sweep(NS);
    check_val("s4_en1", sensors_en_o[1], 1'b1);
    check_val("s4_byte1", sensors_data_o[DW +: DW], DW'(val[1]));

    // Reset while sensor 2 is being polled, then a full fresh sweep.
    set_sweep(2, 1'b0);
    run_sweep(2);
    check_val("abort_snap", {sensors_data_o, sensors_en_o, frame_valid_o}, '0);
    set_sweep(5, 1'b1);
    run_sweep(NS);

    for (int k = 0; k < 8; k++) begin
      set_sweep(20, 1'b1);
      run_sweep(NS);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
